motor_ramp_controller: RTL
==========================

Name: motor_ramp_controller

Overview:
Sequences the duty-cycle input of one Motor_Driver phase bridge. Captures a commanded target duty, slews duty_cycle toward it at a bounded rate, and ramps down to zero on disable. Monitors the hall inputs for invalid codes and for stall, and forces duty to zero on fault. Sits between the command/SPI register file and Motor_Driver; there is one instance per motor.

Parameters:
DUTY_WIDTH, 8, width of duty values; matches `DUTY_CYCLE_WIDTH.
RAMP_DIV, 16, clock cycles between ramp steps.
RAMP_STEP, 4, duty increment or decrement per ramp step.
HALL_FAULT_CYCLES, 8, consecutive synchronized invalid hall cycles that cause a fault.
STALL_CYCLES, 4096, cycles without a hall edge at or above STALL_MIN_DUTY that cause a fault.
STALL_MIN_DUTY, 8'h20, duty below which stall detection is suspended.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
enable  in  1  motor run request.
target_duty  in  DUTY_WIDTH  commanded duty.
target_load  in  1  captures target_duty on the same edge.
fault_clear  in  1  fault acknowledge.
hall  in  3  raw hall sensor inputs (asynchronous).
duty_cycle  out  DUTY_WIDTH  drives the Motor_Driver duty_cycle input.
running  out  1  state is ACTIVE or SHUTDOWN.
at_target  out  1  state is ACTIVE and duty_cycle == target.
hall_fault  out  1  sticky invalid-hall fault.
stall_fault  out  1  sticky stall fault.

Behaviour:
- Reset (sync, any state, including mid-ramp) sets on the next edge:
  - duty_cycle = 0, target register = 0, state = IDLE.
  - All flags = 0.
  - Ramp, hall-fault and stall counters = 0.
  - Hall synchronizer = 0.
- Hall path:
  - 2-flop synchronizer, then a prev register.
  - A "hall edge" is sync != prev, so detection latency is 2 cycles.
  - Codes 000 and 111 are invalid.
- target_load captures target_duty in every state except FAULT, where it is ignored.
- States and transitions:
  - IDLE: duty = 0. enable=1 moves to ACTIVE and clears the ramp counter.
  - ACTIVE: slews toward target. enable=0 moves to SHUTDOWN.
  - SHUTDOWN: slews toward 0; the target register is preserved. duty==0 moves to IDLE. enable=1 moves to ACTIVE and resumes from the current duty without a reset.
  - FAULT: duty_cycle = 0 on the edge of entry (no ramp). Exit to IDLE only when fault_clear=1 AND enable=0; this clears both flags and all counters. fault_clear with enable=1 is ignored.
- Ramp:
  - Counter runs 0..RAMP_DIV-1; a tick occurs when counter == RAMP_DIV-1.
  - On a tick: if duty < goal, duty = min(duty+RAMP_STEP, goal); if duty > goal, duty = max(duty-RAMP_STEP, goal).
  - Arithmetic uses DUTY_WIDTH+1 bits. No wrap and no overshoot.
  - A target change mid-ramp takes effect on the next tick.
- Hall fault (ACTIVE or SHUTDOWN only):
  - Counter increments while the synchronized code is invalid and clears on a valid code.
  - Reaching HALL_FAULT_CYCLES sets hall_fault=1 and enters FAULT.
- Stall (ACTIVE or SHUTDOWN only):
  - Counter clears on a hall edge or when duty < STALL_MIN_DUTY; otherwise it increments.
  - Reaching STALL_CYCLES sets stall_fault=1 and enters FAULT.
- Both faults on the same cycle set both flags.
- Fault detection takes priority over enable/ramp transitions in that cycle.
- at_target is combinational from registered state and regs. All other outputs are registered.

Test Plan:
1. Reset, enable=1, load 0x80, hall rotating every 100 cycles -> duty steps +4 every 16 cycles, reaches 0x80 at cycle 512 (±2), at_target=1, running=1, no faults.
2. Load 0x82 from 0x80 -> one step to 0x82, no overshoot. Then load 0x10 -> monotone down by 4 per tick, ending exactly 0x10.
3. Disable at duty 0x40 -> 16 ticks to 0, then IDLE, running=0. Repeat, re-enabling at duty 0x20 -> ramps back up from 0x20 toward the retained target 0x40.
4. ACTIVE with hall=111 for 7 cycles, then valid -> no fault. Hall=000 for 8 synchronized cycles -> hall_fault=1, FAULT, duty=0 next edge, target_load ignored.
5. Duty 0x80 with hall frozen at 101 -> stall_fault after 4096 cycles, duty=0. Duty 0x10 with frozen hall for 10000 cycles -> no fault.
6. In FAULT, fault_clear with enable=1 -> stays FAULT. With enable=0 -> IDLE, flags 0. Reset asserted mid-ramp at duty 0x3C -> duty=0 and state IDLE next edge.

Source files
------------

// File: rtl/motor_ramp_controller.sv
// motor_ramp_controller
// Drives the duty_cycle input of one Motor_Driver phase bridge. The
// commanded target is approached at a bounded slew rate. On disable, duty
// ramps down to zero. Invalid hall codes or a stalled rotor force duty to
// zero and latch a sticky fault flag until the fault is acknowledged with
// the motor disabled.
module motor_ramp_controller #(
    parameter int                    DUTY_WIDTH        = 8,
    parameter int                    RAMP_DIV          = 16,
    parameter int                    RAMP_STEP         = 4,
    parameter int                    HALL_FAULT_CYCLES = 8,
    parameter int                    STALL_CYCLES      = 4096,
    parameter logic [DUTY_WIDTH-1:0] STALL_MIN_DUTY    = 8'h20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DUTY_WIDTH-1:0] target_duty,
    input  logic                  target_load,
    input  logic                  fault_clear,
    input  logic [2:0]            hall,
    output logic [DUTY_WIDTH-1:0] duty_cycle,
    output logic                  running,
    output logic                  at_target,
    output logic                  hall_fault,
    output logic                  stall_fault
);

    localparam int RAMP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int HALL_W  = (HALL_FAULT_CYCLES > 1) ? $clog2(HALL_FAULT_CYCLES) : 1;
    localparam int STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    localparam logic [RAMP_W-1:0]     RAMP_LAST  = RAMP_W'(RAMP_DIV - 1);
    localparam logic [RAMP_W-1:0]     RAMP_ONE   = RAMP_W'(1);
    localparam logic [HALL_W-1:0]     HALL_LAST  = HALL_W'(HALL_FAULT_CYCLES - 1);
    localparam logic [HALL_W-1:0]     HALL_ONE   = HALL_W'(1);
    localparam logic [STALL_W-1:0]    STALL_LAST = STALL_W'(STALL_CYCLES - 1);
    localparam logic [STALL_W-1:0]    STALL_ONE  = STALL_W'(1);
    localparam logic [DUTY_WIDTH:0]   STEP_EXT   = (DUTY_WIDTH + 1)'(RAMP_STEP);
    localparam logic [DUTY_WIDTH-1:0] DUTY_ZERO  = {DUTY_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_SHUTDOWN = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    state_t                state_r;
    logic [DUTY_WIDTH-1:0] duty_r;
    logic [DUTY_WIDTH-1:0] target_r;
    logic                  running_r;
    logic                  hall_fault_r;
    logic                  stall_fault_r;
    logic [RAMP_W-1:0]     ramp_cnt_r;
    logic [HALL_W-1:0]     hall_cnt_r;
    logic [STALL_W-1:0]    stall_cnt_r;
    logic [2:0]            hall_meta_r;
    logic [2:0]            hall_sync_r;
    logic [2:0]            hall_prev_r;

    logic                  moving_s;
    logic                  hall_invalid_s;
    logic                  hall_edge_s;
    logic                  stall_run_s;
    logic                  hall_trip_s;
    logic                  stall_trip_s;
    logic                  ramp_tick_s;
    logic [DUTY_WIDTH-1:0] goal_s;
    logic [DUTY_WIDTH:0]   duty_ext_s;
    logic [DUTY_WIDTH:0]   goal_ext_s;
    logic [DUTY_WIDTH:0]   sum_ext_s;
    logic [DUTY_WIDTH-1:0] duty_step_s;
    logic [DUTY_WIDTH-1:0] duty_next_s;

    assign duty_cycle  = duty_r;
    assign running     = running_r;
    assign hall_fault  = hall_fault_r;
    assign stall_fault = stall_fault_r;
    assign at_target   = (state_r == ST_ACTIVE) && (duty_r == target_r);

    // Hall decode and fault trip conditions for the current cycle
    always_comb begin
        moving_s       = 1'b0;
        hall_invalid_s = 1'b0;
        hall_edge_s    = 1'b0;
        stall_run_s    = 1'b0;
        hall_trip_s    = 1'b0;
        stall_trip_s   = 1'b0;
        if ((state_r == ST_ACTIVE) || (state_r == ST_SHUTDOWN)) begin
            moving_s = 1'b1;
        end else begin
            moving_s = 1'b0;
        end
        if ((hall_sync_r == 3'b000) || (hall_sync_r == 3'b111)) begin
            hall_invalid_s = 1'b1;
        end else begin
            hall_invalid_s = 1'b0;
        end
        hall_edge_s  = (hall_sync_r != hall_prev_r);
        // Stall timing is suspended at low duty where the rotor may not turn
        stall_run_s  = !hall_edge_s && (duty_r >= STALL_MIN_DUTY);
        hall_trip_s  = moving_s && hall_invalid_s && (hall_cnt_r == HALL_LAST);
        stall_trip_s = moving_s && stall_run_s && (stall_cnt_r == STALL_LAST);
    end

    // Next ramp value: one bounded step toward the goal, clamped at the goal
    always_comb begin
        ramp_tick_s = (ramp_cnt_r == RAMP_LAST);
        if (state_r == ST_ACTIVE) begin
            goal_s = target_r;
        end else begin
            goal_s = DUTY_ZERO;
        end
        // One extra bit keeps duty+step from wrapping past full scale
        duty_ext_s  = {1'b0, duty_r};
        goal_ext_s  = {1'b0, goal_s};
        sum_ext_s   = duty_ext_s + STEP_EXT;
        duty_step_s = duty_r;
        if (duty_ext_s < goal_ext_s) begin
            if (sum_ext_s > goal_ext_s) begin
                duty_step_s = goal_s;
            end else begin
                duty_step_s = sum_ext_s[DUTY_WIDTH-1:0];
            end
        end else if (duty_ext_s > goal_ext_s) begin
            if (duty_ext_s >= (goal_ext_s + STEP_EXT)) begin
                duty_step_s = duty_r - STEP_EXT[DUTY_WIDTH-1:0];
            end else begin
                duty_step_s = goal_s;
            end
        end else begin
            duty_step_s = duty_r;
        end
        if (ramp_tick_s) begin
            duty_next_s = duty_step_s;
        end else begin
            duty_next_s = duty_r;
        end
    end

    // Two-flop hall synchronizer followed by the edge-detect history register
    always_ff @(posedge clock) begin
        if (reset) begin
            hall_meta_r <= 3'b000;
            hall_sync_r <= 3'b000;
            hall_prev_r <= 3'b000;
        end else begin
            hall_meta_r <= hall;
            hall_sync_r <= hall_meta_r;
            hall_prev_r <= hall_sync_r;
        end
    end

    // Run-state sequencer: ramping, fault detection and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            duty_r        <= DUTY_ZERO;
            target_r      <= DUTY_ZERO;
            running_r     <= 1'b0;
            hall_fault_r  <= 1'b0;
            stall_fault_r <= 1'b0;
            ramp_cnt_r    <= '0;
            hall_cnt_r    <= '0;
            stall_cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    duty_r      <= DUTY_ZERO;
                    ramp_cnt_r  <= '0;
                    hall_cnt_r  <= '0;
                    stall_cnt_r <= '0;
                    if (target_load) begin
                        target_r <= target_duty;
                    end
                    if (enable) begin
                        state_r   <= ST_ACTIVE;
                        running_r <= 1'b1;
                    end
                end
                ST_ACTIVE, ST_SHUTDOWN: begin
                    if (target_load) begin
                        target_r <= target_duty;
                    end
                    // A fault wins over any ramp step or enable change this cycle
                    if (hall_trip_s || stall_trip_s) begin
                        state_r       <= ST_FAULT;
                        duty_r        <= DUTY_ZERO;
                        running_r     <= 1'b0;
                        hall_fault_r  <= hall_trip_s;
                        stall_fault_r <= stall_trip_s;
                        ramp_cnt_r    <= '0;
                        hall_cnt_r    <= '0;
                        stall_cnt_r   <= '0;
                    end else begin
                        duty_r     <= duty_next_s;
                        ramp_cnt_r <= ramp_tick_s ? '0 : (ramp_cnt_r + RAMP_ONE);
                        hall_cnt_r <= hall_invalid_s ? (hall_cnt_r + HALL_ONE) : '0;
                        stall_cnt_r <= stall_run_s ? (stall_cnt_r + STALL_ONE) : '0;
                        if (state_r == ST_ACTIVE) begin
                            if (!enable) begin
                                state_r <= ST_SHUTDOWN;
                            end
                        end else if (enable) begin
                            // Resume from the present duty; the ramp phase carries on
                            state_r <= ST_ACTIVE;
                        end else if (duty_r == DUTY_ZERO) begin
                            state_r   <= ST_IDLE;
                            running_r <= 1'b0;
                        end
                    end
                end
                ST_FAULT: begin
                    duty_r    <= DUTY_ZERO;
                    running_r <= 1'b0;
                    // Acknowledge only counts once the run request has been dropped
                    if (fault_clear && !enable) begin
                        state_r       <= ST_IDLE;
                        hall_fault_r  <= 1'b0;
                        stall_fault_r <= 1'b0;
                        ramp_cnt_r    <= '0;
                        hall_cnt_r    <= '0;
                        stall_cnt_r   <= '0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    duty_r    <= DUTY_ZERO;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
